// File: rtl/pc_attack_engine.sv
// Computer-side attack engine: picks a not-yet-attacked cell on the player's board,
// records HIT/MISS, tracks the remaining player ships and pulses pc_move once per PC turn.
module pc_attack_engine #(
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    parameter int         MAX_TRIES   = 16,
    parameter int         BOARD_CELLS = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pc_turn_State,
    input  logic       load_ships,
    input  logic [2:0] ships_init,
    output logic [4:0] board_rd_addr,
    input  logic [1:0] board_rd_data,
    output logic       board_wr_en,
    output logic [4:0] board_wr_addr,
    output logic [1:0] board_wr_data,
    output logic       pc_move,
    output logic [2:0] player_ships,
    output logic [4:0] last_addr,
    output logic       last_hit,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PICK,
        S_WAIT,
        S_EVAL,
        S_SCAN_WAIT,
        S_SCAN_EVAL,
        S_WRITE,
        S_DONE,
        S_HOLD
    } state_t;

    localparam logic [4:0] LAST_CELL = 5'(BOARD_CELLS - 1);
    localparam logic [7:0] MAX_T     = 8'(MAX_TRIES);

    state_t     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] tries_q, tries_d;
    logic [4:0] rd_addr_q, rd_addr_d;
    logic       ship_q, ship_d;
    logic [2:0] ships_q, ships_d;
    logic [4:0] last_addr_q, last_addr_d;
    logic       last_hit_q, last_hit_d;
    logic [4:0] cand;

    assign cand = lfsr_q[4:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            lfsr_q      <= LFSR_SEED;
            tries_q     <= 8'd0;
            rd_addr_q   <= 5'd0;
            ship_q      <= 1'b0;
            ships_q     <= 3'd0;
            last_addr_q <= 5'd0;
            last_hit_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            tries_q     <= tries_d;
            rd_addr_q   <= rd_addr_d;
            ship_q      <= ship_d;
            ships_q     <= ships_d;
            last_addr_q <= last_addr_d;
            last_hit_q  <= last_hit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        // Free-running so that the chosen cell depends on when the turn starts.
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        tries_d     = tries_q;
        rd_addr_d   = rd_addr_q;
        ship_d      = ship_q;
        ships_d     = ships_q;
        last_addr_d = last_addr_q;
        last_hit_d  = last_hit_q;

        case (state_q)
            S_IDLE: begin
                if (load_ships) begin
                    ships_d     = ships_init;
                    last_addr_d = 5'd0;
                    last_hit_d  = 1'b0;
                end
                if (pc_turn_State && ships_q != 3'd0) begin
                    tries_d = 8'd0;
                    state_d = S_PICK;
                end
            end
            S_PICK: begin
                if (tries_q >= MAX_T) begin
                    rd_addr_d = 5'd0;
                    state_d   = S_SCAN_WAIT;
                end else if (cand > LAST_CELL) begin
                    tries_d = tries_q + 8'd1;
                end else begin
                    rd_addr_d = cand;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: state_d = S_EVAL;
            S_EVAL: begin
                if (!board_rd_data[1]) begin
                    ship_d  = board_rd_data[0];
                    state_d = S_WRITE;
                end else begin
                    tries_d = tries_q + 8'd1;
                    if (tries_q + 8'd1 >= MAX_T) begin
                        rd_addr_d = 5'd0;
                        state_d   = S_SCAN_WAIT;
                    end else begin
                        state_d = S_PICK;
                    end
                end
            end
            S_SCAN_WAIT: state_d = S_SCAN_EVAL;
            S_SCAN_EVAL: begin
                if (!board_rd_data[1]) begin
                    ship_d  = board_rd_data[0];
                    state_d = S_WRITE;
                end else if (rd_addr_q == LAST_CELL) begin
                    // Board fully attacked: finish the turn without writing.
                    state_d = S_DONE;
                end else begin
                    rd_addr_d = rd_addr_q + 5'd1;
                    state_d   = S_SCAN_WAIT;
                end
            end
            S_WRITE: begin
                last_addr_d = rd_addr_q;
                last_hit_d  = ship_q;
                if (ship_q && ships_q != 3'd0) ships_d = ships_q - 3'd1;
                state_d = S_DONE;
            end
            S_DONE: state_d = S_HOLD;
            S_HOLD: begin
                if (!pc_turn_State) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign board_rd_addr = rd_addr_q;
    assign board_wr_en   = (state_q == S_WRITE);
    assign board_wr_addr = board_wr_en ? rd_addr_q : 5'd0;
    assign board_wr_data = board_wr_en ? {1'b1, ship_q} : 2'b00;
    assign pc_move       = (state_q == S_DONE);
    assign player_ships  = ships_q;
    assign last_addr     = last_addr_q;
    assign last_hit      = last_hit_q;
    assign busy          = (state_q != S_IDLE) && (state_q != S_HOLD);

endmodule

// File: tb/tb_pc_attack_engine.sv
// Directed bench for pc_attack_engine with a behavioural player-board RAM (1-cycle read latency).
module tb_pc_attack_engine;

    localparam int LAT_MIN = 5;
    localparam int LAT_MAX = 1 + 3 * 16 + 2 * 25 + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pc_turn_State = 1'b0;
    logic       load_ships = 1'b0;
    logic [2:0] ships_init = 3'd0;
    logic [4:0] board_rd_addr;
    logic [1:0] board_rd_data = 2'b00;
    logic       board_wr_en;
    logic [4:0] board_wr_addr;
    logic [1:0] board_wr_data;
    logic       pc_move;
    logic [2:0] player_ships;
    logic [4:0] last_addr;
    logic       last_hit;
    logic       busy;

    logic [1:0] mem [0:24];

    int errors = 0;
    int checks = 0;
    int move_cnt = 0;
    int wr_cnt = 0;
    int bad_wr = 0;
    int busy_cnt = 0;
    logic [4:0] seen_wa = 5'd0;
    logic [1:0] seen_wd = 2'b00;

    pc_attack_engine dut (
        .clk(clk), .rst(rst), .pc_turn_State(pc_turn_State), .load_ships(load_ships),
        .ships_init(ships_init), .board_rd_addr(board_rd_addr), .board_rd_data(board_rd_data),
        .board_wr_en(board_wr_en), .board_wr_addr(board_wr_addr), .board_wr_data(board_wr_data),
        .pc_move(pc_move), .player_ships(player_ships), .last_addr(last_addr),
        .last_hit(last_hit), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        board_rd_data <= (board_rd_addr < 5'd25) ? mem[board_rd_addr] : 2'b00;
        if (board_wr_en && board_wr_addr < 5'd25) mem[board_wr_addr] = board_wr_data;
    end

    always @(negedge clk) begin
        if (rst) begin
            if (pc_move) move_cnt++;
            if (busy) busy_cnt++;
            if (board_wr_en) begin
                wr_cnt++;
                seen_wa = board_wr_addr;
                seen_wd = board_wr_data;
                if (board_wr_addr >= 5'd25 || board_wr_data[1] !== 1'b1) bad_wr++;
            end
        end
    end

    task automatic fill(input logic [1:0] v);
        for (int i = 0; i < 25; i++) mem[i] = v;
    endtask

    function automatic int count_val(input logic [1:0] v);
        int n = 0;
        for (int i = 0; i < 25; i++) if (mem[i] === v) n++;
        return n;
    endfunction

    task automatic do_load(input logic [2:0] n);
        @(negedge clk);
        load_ships = 1'b1;
        ships_init = n;
        @(negedge clk);
        load_ships = 1'b0;
    endtask

    task automatic run_turn(output int lat);
        bit seen = 0;
        lat = 0;
        pc_turn_State = 1'b1;
        while (!seen && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (pc_move) seen = 1;
        end
        repeat (2) @(negedge clk);
        pc_turn_State = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (board_rd_addr !== 5'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", board_rd_addr); end
        checks++; if (board_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0b expected 0", board_wr_en); end
        checks++; if (board_wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d expected 0", board_wr_addr); end
        checks++; if (board_wr_data !== 2'b00) begin errors++; $display("FAIL reset_wr_data: got %0d expected 0", board_wr_data); end
        checks++; if (pc_move !== 1'b0) begin errors++; $display("FAIL reset_pc_move: got %0b expected 0", pc_move); end
        checks++; if (player_ships !== 3'd0) begin errors++; $display("FAIL reset_ships: got %0d expected 0", player_ships); end
        checks++; if (last_addr !== 5'd0) begin errors++; $display("FAIL reset_last_addr: got %0d expected 0", last_addr); end
        checks++; if (last_hit !== 1'b0) begin errors++; $display("FAIL reset_last_hit: got %0b expected 0", last_hit); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_hit();
        int lat, m0, w0, b0;
        fill(2'b01);
        do_load(3'd3);
        m0 = move_cnt; w0 = wr_cnt; b0 = bad_wr;
        run_turn(lat);
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL hit_writes: got %0d expected 1", wr_cnt - w0); end
        checks++; if (seen_wd !== 2'b11) begin errors++; $display("FAIL hit_wr_data: got %0d expected 3", seen_wd); end
        checks++; if (bad_wr - b0 !== 0) begin errors++; $display("FAIL hit_bad_write: got %0d expected 0", bad_wr - b0); end
        checks++; if (player_ships !== 3'd2) begin errors++; $display("FAIL hit_ships: got %0d expected 2", player_ships); end
        checks++; if (last_hit !== 1'b1) begin errors++; $display("FAIL hit_last_hit: got %0b expected 1", last_hit); end
        checks++; if (last_addr !== seen_wa) begin errors++; $display("FAIL hit_last_addr: got %0d expected %0d", last_addr, seen_wa); end
        checks++; if (move_cnt - m0 !== 1) begin errors++; $display("FAIL hit_moves: got %0d expected 1", move_cnt - m0); end
        checks++; if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("FAIL hit_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX); end
        checks++; if (count_val(2'b11) !== 1) begin errors++; $display("FAIL hit_board: got %0d hit cells expected 1", count_val(2'b11)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hit_busy_after: got %0b expected 0", busy); end
    endtask

    task automatic test_miss();
        int lat, m0, w0;
        fill(2'b00);
        do_load(3'd3);
        m0 = move_cnt; w0 = wr_cnt;
        run_turn(lat);
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL miss_writes: got %0d expected 1", wr_cnt - w0); end
        checks++; if (seen_wd !== 2'b10) begin errors++; $display("FAIL miss_wr_data: got %0d expected 2", seen_wd); end
        checks++; if (seen_wa >= 5'd25) begin errors++; $display("FAIL miss_wr_addr: got %0d expected <25", seen_wa); end
        checks++; if (player_ships !== 3'd3) begin errors++; $display("FAIL miss_ships: got %0d expected 3", player_ships); end
        checks++; if (last_hit !== 1'b0) begin errors++; $display("FAIL miss_last_hit: got %0b expected 0", last_hit); end
        checks++; if (move_cnt - m0 !== 1) begin errors++; $display("FAIL miss_moves: got %0d expected 1", move_cnt - m0); end
        checks++; if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("FAIL miss_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX); end
    endtask

    task automatic test_last_cell();
        int lat, m0, w0;
        for (int i = 0; i < 24; i++) mem[i] = (i % 2 == 0) ? 2'b10 : 2'b11;
        mem[24] = 2'b01;
        do_load(3'd3);
        m0 = move_cnt; w0 = wr_cnt;
        run_turn(lat);
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL last_writes: got %0d expected 1", wr_cnt - w0); end
        checks++; if (seen_wa !== 5'd24) begin errors++; $display("FAIL last_wr_addr: got %0d expected 24", seen_wa); end
        checks++; if (seen_wd !== 2'b11) begin errors++; $display("FAIL last_wr_data: got %0d expected 3", seen_wd); end
        checks++; if (player_ships !== 3'd2) begin errors++; $display("FAIL last_ships: got %0d expected 2", player_ships); end
        checks++; if (last_addr !== 5'd24) begin errors++; $display("FAIL last_last_addr: got %0d expected 24", last_addr); end
        checks++; if (move_cnt - m0 !== 1) begin errors++; $display("FAIL last_moves: got %0d expected 1", move_cnt - m0); end
        checks++; if (lat > LAT_MAX) begin errors++; $display("FAIL last_latency: got %0d expected <=%0d", lat, LAT_MAX); end
    endtask

    task automatic test_all_attacked();
        int lat, m0, w0;
        for (int i = 0; i < 25; i++) mem[i] = (i % 3 == 0) ? 2'b11 : 2'b10;
        m0 = move_cnt; w0 = wr_cnt;
        run_turn(lat);
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL full_writes: got %0d expected 0", wr_cnt - w0); end
        checks++; if (move_cnt - m0 !== 1) begin errors++; $display("FAIL full_moves: got %0d expected 1", move_cnt - m0); end
        checks++; if (last_addr !== 5'd24) begin errors++; $display("FAIL full_last_addr: got %0d expected 24", last_addr); end
        checks++; if (last_hit !== 1'b1) begin errors++; $display("FAIL full_last_hit: got %0b expected 1", last_hit); end
        checks++; if (player_ships !== 3'd2) begin errors++; $display("FAIL full_ships: got %0d expected 2", player_ships); end
        checks++; if (lat > LAT_MAX) begin errors++; $display("FAIL full_latency: got %0d expected <=%0d", lat, LAT_MAX); end
    endtask

    task automatic test_long_turn();
        int m0, w0;
        fill(2'b00);
        do_load(3'd3);
        m0 = move_cnt; w0 = wr_cnt;
        pc_turn_State = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            load_ships = (i == 150);
            ships_init = 3'd5;
        end
        @(negedge clk);
        load_ships = 1'b0;
        pc_turn_State = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (move_cnt - m0 !== 1) begin errors++; $display("FAIL long_moves: got %0d expected 1", move_cnt - m0); end
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL long_writes: got %0d expected 1", wr_cnt - w0); end
        checks++; if (player_ships !== 3'd3) begin errors++; $display("FAIL long_load_ignored: got %0d expected 3", player_ships); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL long_busy_after: got %0b expected 0", busy); end
    endtask

    task automatic test_zero_ships();
        int m0, w0, u0;
        fill(2'b01);
        do_load(3'd0);
        m0 = move_cnt; w0 = wr_cnt; u0 = busy_cnt;
        pc_turn_State = 1'b1;
        repeat (20) @(negedge clk);
        pc_turn_State = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (move_cnt - m0 !== 0) begin errors++; $display("FAIL zero_moves: got %0d expected 0", move_cnt - m0); end
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL zero_writes: got %0d expected 0", wr_cnt - w0); end
        checks++; if (busy_cnt - u0 !== 0) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 0", busy_cnt - u0); end
    endtask

    task automatic test_reset_mid_write();
        int n, m0;
        fill(2'b01);
        do_load(3'd3);
        n = 0;
        pc_turn_State = 1'b1;
        while (!board_wr_en && n < 120) begin
            @(negedge clk);
            n++;
        end
        checks++; if (board_wr_en !== 1'b1) begin errors++; $display("FAIL rstw_reached_write: got %0b expected 1", board_wr_en); end
        rst = 1'b0;
        #1;
        checks++; if (board_wr_en !== 1'b0) begin errors++; $display("FAIL rstw_wr_en: got %0b expected 0", board_wr_en); end
        checks++; if (pc_move !== 1'b0) begin errors++; $display("FAIL rstw_pc_move: got %0b expected 0", pc_move); end
        checks++; if (player_ships !== 3'd0) begin errors++; $display("FAIL rstw_ships: got %0d expected 0", player_ships); end
        pc_turn_State = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m0 = move_cnt;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstw_busy: got %0b expected 0", busy); end
        checks++; if (count_val(2'b11) !== 0) begin errors++; $display("FAIL rstw_no_write: got %0d hit cells expected 0", count_val(2'b11)); end
        checks++; if (move_cnt - m0 !== 0) begin errors++; $display("FAIL rstw_moves: got %0d expected 0", move_cnt - m0); end
        checks++; if (last_addr !== 5'd0) begin errors++; $display("FAIL rstw_last_addr: got %0d expected 0", last_addr); end
    endtask

    initial begin
        fill(2'b00);
        test_reset();
        test_hit();
        test_miss();
        test_last_cell();
        test_all_attacked();
        test_long_turn();
        test_zero_ships();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
